// File: rtl/imem_loader_pkg.sv
// Shared loader definitions: FSM encodings and stream framing constants.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        BYTES  = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 2;

endpackage

// File: rtl/imem_loader.sv
// Instruction-memory loader: 16-bit LE word-count header, then LE-packed words, one write per 4 bytes.
// Latency: write one cycle after the 4th byte of a word; backpressure via rx_ready, low outside header/payload states.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] IM_addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err
);

    state_t      state, state_nxt;
    logic [15:0] len;
    logic [5:0]  word_cnt;
    logic [1:0]  byte_cnt;
    logic [23:0] word_buf;
    logic        accept;
    logic        last_byte;
    logic [15:0] len_full;
    logic [5:0]  word_cnt_inc;

    assign accept       = rx_valid && rx_ready;
    assign last_byte    = (byte_cnt == 2'(BYTES_PER_WORD - 1));
    assign len_full     = {rx_data, len[7:0]};
    assign word_cnt_inc = word_cnt + 6'd1;

    // All handshake/status outputs are pure state decodes.
    assign rx_ready = (state == LEN_LO) || (state == LEN_HI) || (state == BYTES);
    assign we       = (state == WRITE);
    assign cpu_hold = (state == LEN_LO) || (state == LEN_HI) || (state == BYTES) ||
                      (state == WRITE)  || (state == ERR);
    assign done     = (state == DONE);
    assign err      = (state == ERR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_nxt = LEN_LO;
            LEN_LO:          if (accept) state_nxt = LEN_HI;
            LEN_HI: begin
                if (accept) begin
                    if (len_full == 16'd0)                 state_nxt = DONE;
                    else if (len_full > 16'(DEPTH / 4))    state_nxt = ERR;
                    else                                   state_nxt = BYTES;
                end
            end
            BYTES:           if (accept && last_byte) state_nxt = WRITE;
            WRITE:           state_nxt = ({10'd0, word_cnt_inc} == len) ? DONE : BYTES;
            default:         state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len      <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            word_buf <= '0;
            IM_addr  <= '0;
            data     <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        len      <= '0;
                        word_cnt <= '0;
                        byte_cnt <= '0;
                    end
                end
                LEN_LO: if (accept) len[7:0]  <= rx_data;
                LEN_HI: if (accept) len[15:8] <= rx_data;
                BYTES: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        word_buf <= {rx_data, word_buf[23:8]};
                        // Address/data load only here so they hold steady outside WRITE.
                        if (last_byte) begin
                            data    <= DATA_WIDTH'({rx_data, word_buf});
                            IM_addr <= ADDR_WIDTH'({word_cnt, 2'b00});
                        end
                    end
                end
                WRITE:   word_cnt <= word_cnt_inc;
                default: ;
            endcase
        end
    end

endmodule
